// File: rtl/limits_iter_sequencer.sv
// Run sequencer for the limits buffer controller: one frame load phase, then
// num_iterations replay phases separated by pipeline-drain gaps.
module limits_iter_sequencer #(
    parameter int MAX_SAMPLES_IN_RAM = 255,
    parameter int GAP_CYCLES         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] num_iterations,
    input  logic       lvl_gen_valid,
    input  logic       ram_waitrequest_a,
    input  logic       ram_waitrequest_b,
    output logic       iter_input_enable,
    output logic       iter_output_enable,
    output logic       busy,
    output logic       done,
    output logic       cfg_error,
    output logic [7:0] iter_index
);

    localparam logic [7:0] LAST_SAMPLE = 8'(MAX_SAMPLES_IN_RAM - 1);
    localparam logic [3:0] LAST_GAP    = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_GAP  = 3'd2,
        S_ITER = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_sample_cnt;
    logic [3:0] r_gap_cnt;
    logic [7:0] r_iter_cnt;
    logic [7:0] r_num_iter;
    logic       r_cfg_error;

    logic       w_accept_a;
    logic       w_accept_b;
    logic       w_last_sample;
    logic       w_last_iter;

    assign w_accept_a    = lvl_gen_valid & ~ram_waitrequest_a;
    assign w_accept_b    = ~ram_waitrequest_b;
    assign w_last_sample = (r_sample_cnt == LAST_SAMPLE);
    assign w_last_iter   = (r_iter_cnt == (r_num_iter - 8'd1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_gap_cnt    <= '0;
            r_iter_cnt   <= '0;
            r_num_iter   <= '0;
            r_cfg_error  <= 1'b0;
        end else begin
            r_cfg_error <= 1'b0;
            if (abort) begin
                // Buffer controller counters are left misaligned; software resets before rerun.
                r_state      <= S_IDLE;
                r_sample_cnt <= '0;
                r_gap_cnt    <= '0;
                r_iter_cnt   <= '0;
                r_num_iter   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_iter_cnt <= '0;
                        if (start) begin
                            if (num_iterations != 8'd0) begin
                                r_num_iter <= num_iterations;
                                r_state    <= S_LOAD;
                            end else begin
                                r_cfg_error <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_accept_a) begin
                            if (w_last_sample) begin
                                r_sample_cnt <= '0;
                                r_state      <= S_GAP;
                            end else begin
                                r_sample_cnt <= r_sample_cnt + 8'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == LAST_GAP) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_ITER;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 4'd1;
                        end
                    end
                    S_ITER: begin
                        if (w_accept_b) begin
                            if (w_last_sample) begin
                                r_sample_cnt <= '0;
                                if (w_last_iter) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_iter_cnt <= r_iter_cnt + 8'd1;
                                    r_state    <= S_GAP;
                                end
                            end else begin
                                r_sample_cnt <= r_sample_cnt + 8'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_iter_cnt <= '0;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Pure decodes of registered state: no input reaches an output combinationally.
    assign iter_input_enable  = (r_state == S_LOAD);
    assign iter_output_enable = (r_state == S_ITER);
    assign busy               = (r_state != S_IDLE);
    assign done               = (r_state == S_DONE);
    assign cfg_error          = r_cfg_error;
    assign iter_index         = r_iter_cnt;

endmodule

// File: tb/tb_limits_iter_sequencer.sv
// Directed bench for limits_iter_sequencer with an 8-sample frame and 2-cycle gap.
module tb_limits_iter_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] num_iterations;
    logic       lvl_gen_valid;
    logic       ram_waitrequest_a;
    logic       ram_waitrequest_b;
    logic       iter_input_enable;
    logic       iter_output_enable;
    logic       busy;
    logic       done;
    logic       cfg_error;
    logic [7:0] iter_index;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    limits_iter_sequencer #(
        .MAX_SAMPLES_IN_RAM(8),
        .GAP_CYCLES        (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .num_iterations    (num_iterations),
        .lvl_gen_valid     (lvl_gen_valid),
        .ram_waitrequest_a (ram_waitrequest_a),
        .ram_waitrequest_b (ram_waitrequest_b),
        .iter_input_enable (iter_input_enable),
        .iter_output_enable(iter_output_enable),
        .busy              (busy),
        .done              (done),
        .cfg_error         (cfg_error),
        .iter_index        (iter_index)
    );

    // Observed vector layout: {busy, in_en, out_en, done, cfg_error, iter_index}
    logic [12:0] obs;
    assign obs = {busy, iter_input_enable, iter_output_enable, done, cfg_error, iter_index};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        start             = 1'b0;
        abort             = 1'b0;
        num_iterations    = 8'd0;
        lvl_gen_valid     = 1'b0;
        ram_waitrequest_a = 1'b0;
        ram_waitrequest_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet_inputs();
        start = 1'b1;
        num_iterations = 8'd3;
        lvl_gen_valid = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", obs, 13'd0);
        end
        reset = 1'b0;
        quiet_inputs();
        tick();
        $display("test_reset done");
    endtask

    // Steady inputs, 3 iterations: LOAD c1-8, then (GAP 2 + ITER 8) x3, DONE at c39.
    task automatic test_basic_run();
        logic [12:0] exp_v;
        logic        eb, ei, eo, ed;
        logic [7:0]  eidx;
        int          k, r;
        lvl_gen_valid  = 1'b1;
        num_iterations = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_iterations = 8'd0;
        for (int c = 1; c <= 40; c++) begin
            eb = 1'b1; ei = 1'b0; eo = 1'b0; ed = 1'b0; eidx = 8'd0;
            if (c <= 8) begin
                ei = 1'b1;
            end else if (c <= 38) begin
                k = (c - 9) / 10;
                r = (c - 9) % 10;
                eidx = 8'(k);
                eo = (r >= 2);
            end else if (c == 39) begin
                ed = 1'b1;
                eidx = 8'd2;
            end else begin
                eb = 1'b0;
            end
            exp_v = {eb, ei, eo, ed, 1'b0, eidx};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL basic_run c%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        quiet_inputs();
        $display("test_basic_run done");
    endtask

    // Valid toggles, waitrequest_a stalls c5-7: 8th accept lands at c19.
    task automatic test_stall_a();
        logic [12:0] exp_v;
        logic        eb, ei, eo, ed;
        int          acc, load_end, rel;
        acc = 0;
        load_end = 0;
        num_iterations = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_iterations = 8'd0;
        for (int c = 1; c <= 60; c++) begin
            lvl_gen_valid     = (c % 2) == 1;
            ram_waitrequest_a = (c >= 5 && c <= 7);
            eb = 1'b1; ei = 1'b0; eo = 1'b0; ed = 1'b0;
            if (load_end == 0) begin
                ei = 1'b1;
            end else begin
                rel = c - load_end;
                eo = (rel >= 3 && rel <= 10);
                ed = (rel == 11);
                eb = (rel <= 11);
            end
            exp_v = {eb, ei, eo, ed, 1'b0, 8'd0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL stall_a c%0d: got %b want %b", c, obs, exp_v);
            end
            if (load_end == 0 && lvl_gen_valid && !ram_waitrequest_a) begin
                acc++;
                if (acc == 8) load_end = c;
            end
            tick();
            if (load_end != 0 && c == load_end + 12) break;
        end
        n_cmp++;
        if (load_end !== 19) begin
            n_bad++;
            $display("FAIL stall_a_load_end: got %0d want %0d", load_end, 19);
        end
        quiet_inputs();
        $display("test_stall_a done");
    endtask

    // waitrequest_b high c22-26 stretches iteration 1 ITER to c21-33 (13 cycles).
    task automatic test_stall_b();
        logic [12:0] exp_v;
        logic        eb, ei, eo, ed;
        logic [7:0]  eidx;
        lvl_gen_valid  = 1'b1;
        num_iterations = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_iterations = 8'd0;
        for (int c = 1; c <= 35; c++) begin
            ram_waitrequest_b = (c >= 22 && c <= 26);
            eb = 1'b1; ei = 1'b0; eo = 1'b0; ed = 1'b0; eidx = 8'd0;
            if (c <= 8)       ei = 1'b1;
            else if (c <= 10) eidx = 8'd0;
            else if (c <= 18) eo = 1'b1;
            else if (c <= 20) eidx = 8'd1;
            else if (c <= 33) begin eo = 1'b1; eidx = 8'd1; end
            else if (c == 34) begin ed = 1'b1; eidx = 8'd1; end
            else              eb = 1'b0;
            exp_v = {eb, ei, eo, ed, 1'b0, eidx};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL stall_b c%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        quiet_inputs();
        $display("test_stall_b done");
    endtask

    task automatic test_cfg_error();
        logic [12:0] exp_v;
        logic        eb, ei, eo, ed;
        num_iterations = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL cfg_error_pulse: got %b want %b", obs, exp_v);
        end
        tick();
        n_cmp++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL cfg_error_clear: got %b want %b", obs, 13'd0);
        end
        // Run of 1 iteration with a zero-count start injected at c5: must be ignored.
        lvl_gen_valid  = 1'b1;
        num_iterations = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            start          = (c == 5);
            num_iterations = (c == 5) ? 8'd0 : 8'd1;
            eb = 1'b1; ei = 1'b0; eo = 1'b0; ed = 1'b0;
            if (c <= 8)       ei = 1'b1;
            else if (c <= 10) ei = 1'b0;
            else if (c <= 18) eo = 1'b1;
            else if (c == 19) ed = 1'b1;
            else              eb = 1'b0;
            exp_v = {eb, ei, eo, ed, 1'b0, 8'd0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL start_while_busy c%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        quiet_inputs();
        $display("test_cfg_error done");
    endtask

    task automatic test_abort();
        logic [12:0] exp_v;
        logic        eb, ei, eo;
        logic [7:0]  eidx;
        int          k, r;
        lvl_gen_valid  = 1'b1;
        num_iterations = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            abort = (c == 23);
            eb = 1'b1; ei = 1'b0; eo = 1'b0; eidx = 8'd0;
            if (c <= 8) begin
                ei = 1'b1;
            end else if (c <= 23) begin
                k = (c - 9) / 10;
                r = (c - 9) % 10;
                eidx = 8'(k);
                eo = (r >= 2);
            end else begin
                eb = 1'b0;
            end
            exp_v = {eb, ei, eo, 1'b0, 1'b0, eidx};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL abort_iter c%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        abort = 1'b1;
        start = 1'b1;
        num_iterations = 8'd3;
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            n_cmp++;
            if (obs !== 13'd0) begin
                n_bad++;
                $display("FAIL abort_with_start c%0d: got %b want %b", c, obs, 13'd0);
            end
            tick();
        end
        quiet_inputs();
        $display("test_abort done");
    endtask

    task automatic test_reset_mid_run();
        logic [12:0] exp_v;
        logic        eb, ei, eo, ed;
        lvl_gen_valid  = 1'b1;
        num_iterations = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (obs !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_mid_gap: got %b want %b", obs, 13'd0);
        end
        num_iterations = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            eb = 1'b1; ei = 1'b0; eo = 1'b0; ed = 1'b0;
            if (c <= 8)       ei = 1'b1;
            else if (c <= 10) ei = 1'b0;
            else if (c <= 18) eo = 1'b1;
            else if (c == 19) ed = 1'b1;
            else              eb = 1'b0;
            exp_v = {eb, ei, eo, ed, 1'b0, 8'd0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL run_after_reset c%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
        quiet_inputs();
        $display("test_reset_mid_run done");
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        test_reset();
        test_basic_run();
        test_stall_a();
        test_stall_b();
        test_cfg_error();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
